// File: rtl/midi_tx.sv
// MIDI OUT transmitter: encodes note-on/note-off events as channel-voice messages
// (optional running status) and shifts them out as 8N1 UART on tx_out.
`timescale 1ns/1ps

module midi_tx #(
  parameter int CLK_DIV          = 1600,
  parameter bit RUNNING_STATUS   = 1'b1,
  parameter bit NOTE_OFF_AS_VEL0 = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  output logic       ready,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] note_num,
  input  logic [6:0] velocity,
  output logic       tx_out,
  output logic       busy
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLK_DIV - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [1:0]       last_idx;
  logic             rs_valid;
  logic [7:0]       rs_status;
  logic [7:0]       msg0_p0;
  logic [7:0]       msg1_p0;
  logic [7:0]       msg2_p0;

  logic       accept;
  logic       skip;
  logic       baud_end;
  logic       last_byte;
  logic [7:0] new_status;
  logic [7:0] new_data1;
  logic [7:0] new_data2;
  logic [7:0] cur_byte;

  function automatic logic [7:0] status_of(input logic on, input logic [3:0] ch);
    return (on || NOTE_OFF_AS_VEL0) ? {4'h9, ch} : {4'h8, ch};
  endfunction

  function automatic logic [7:0] data2_of(input logic on, input logic [6:0] vel);
    return (!on && NOTE_OFF_AS_VEL0) ? 8'h00 : {1'b0, vel};
  endfunction

  always_comb begin
    accept     = valid && ready;
    new_status = status_of(note_on, channel);
    new_data1  = {1'b0, note_num};
    new_data2  = data2_of(note_on, velocity);
    skip       = RUNNING_STATUS && rs_valid && (rs_status == new_status);
    baud_end   = (baud_cnt == BAUD_LAST);
    last_byte  = (byte_idx == last_idx);
    case (byte_idx)
      2'd0:    cur_byte = msg0_p0;
      2'd1:    cur_byte = msg1_p0;
      default: cur_byte = msg2_p0;
    endcase
  end

  // Stage p0: message bytes captured at accept; a skipped status shifts the data bytes down.
  always_ff @(posedge clk) begin
    if (accept) begin
      rs_status <= new_status;
      if (skip) begin
        msg0_p0 <= new_data1;
        msg1_p0 <= new_data2;
        msg2_p0 <= new_data2;
      end else begin
        msg0_p0 <= new_status;
        msg1_p0 <= new_data1;
        msg2_p0 <= new_data2;
      end
    end
  end

  // Serializer: ready rises one cycle before the final stop ends so a new event
  // accepted on that edge starts its start bit with no idle gap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      last_idx <= '0;
      rs_valid <= 1'b0;
      ready    <= 1'b1;
      tx_out   <= 1'b1;
    end else begin
      case (state)
        START:   tx_out <= 1'b0;
        DATA:    tx_out <= cur_byte[bit_idx];
        default: tx_out <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            ready    <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            last_idx <= skip ? 2'd1 : 2'd2;
            rs_valid <= RUNNING_STATUS;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!last_byte) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
            end else if (accept) begin
              state    <= START;
              ready    <= 1'b0;
              byte_idx <= '0;
              last_idx <= skip ? 2'd1 : 2'd2;
              rs_valid <= RUNNING_STATUS;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            if (last_byte && baud_cnt == BAUD_PRE) ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = ~ready;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: three instances (running status on, off, note-off-as-vel0) driven
// one at a time and checked against a byte-level MIDI/UART reference model.
`timescale 1ns/1ps

module tb_midi_tx;

  localparam int D        = 16;
  localparam int BYTE_CYC = 10 * D;
  localparam int LOG_N    = 32768;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [2:0] busy;
  logic       note_on;
  logic [3:0] channel;
  logic [6:0] note_num;
  logic [6:0] velocity;

  always #5 clk = ~clk;

  midi_tx #(.CLK_DIV(D), .RUNNING_STATUS(1'b1), .NOTE_OFF_AS_VEL0(1'b0)) dut_rs (
    .clk(clk), .reset_n(reset_n), .valid(valid[0]), .ready(ready[0]), .note_on(note_on),
    .channel(channel), .note_num(note_num), .velocity(velocity), .tx_out(tx[0]), .busy(busy[0]));
  midi_tx #(.CLK_DIV(D), .RUNNING_STATUS(1'b0), .NOTE_OFF_AS_VEL0(1'b0)) dut_nors (
    .clk(clk), .reset_n(reset_n), .valid(valid[1]), .ready(ready[1]), .note_on(note_on),
    .channel(channel), .note_num(note_num), .velocity(velocity), .tx_out(tx[1]), .busy(busy[1]));
  midi_tx #(.CLK_DIV(D), .RUNNING_STATUS(1'b1), .NOTE_OFF_AS_VEL0(1'b1)) dut_vel0 (
    .clk(clk), .reset_n(reset_n), .valid(valid[2]), .ready(ready[2]), .note_on(note_on),
    .channel(channel), .note_num(note_num), .velocity(velocity), .tx_out(tx[2]), .busy(busy[2]));

  typedef struct packed {
    logic [1:0]  d;
    logic [31:0] c;
    logic        on;
    logic [3:0]  ch;
    logic [6:0]  n;
    logic [6:0]  v;
  } acc_t;

  acc_t acc_q[$];
  int   cyc = 0;
  logic tx_log  [3][LOG_N];
  logic rdy_log [3][LOG_N];
  int   checks = 0;
  int   errors = 0;

  bit         cfg_rs [3] = '{1'b1, 1'b0, 1'b1};
  bit         cfg_v0 [3] = '{1'b0, 1'b0, 1'b1};
  bit         rs_ok  [3];
  logic [7:0] rs_v   [3];
  logic [7:0] exp_b  [3];
  int         exp_n;

  // Edge counter and accept recorder (sees pre-edge values of valid/ready).
  always @(posedge clk) begin
    acc_t e;
    cyc = cyc + 1;
    if (reset_n) begin
      for (int d = 0; d < 3; d++) begin
        if (valid[d] && ready[d]) begin
          e.d  = 2'(d);
          e.c  = 32'(cyc);
          e.on = note_on;
          e.ch = channel;
          e.n  = note_num;
          e.v  = velocity;
          acc_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      for (int d = 0; d < 3; d++) begin
        tx_log[d][cyc]  = tx[d];
        rdy_log[d][cyc] = ready[d];
      end
    end
  end

  // Reference model: bytes a MIDI transmitter with this configuration must emit.
  task automatic model_msg(input acc_t e);
    int         d;
    logic [7:0] st;
    logic [7:0] vel;
    d = int'(e.d);
    if (e.on || cfg_v0[d]) st = 8'h90 + 8'(e.ch);
    else                   st = 8'h80 + 8'(e.ch);
    vel = (!e.on && cfg_v0[d]) ? 8'h00 : 8'(e.v);
    if (cfg_rs[d] && rs_ok[d] && rs_v[d] == st) begin
      exp_b[0] = 8'(e.n);
      exp_b[1] = vel;
      exp_n    = 2;
    end else begin
      exp_b[0] = st;
      exp_b[1] = 8'(e.n);
      exp_b[2] = vel;
      exp_n    = 3;
      rs_ok[d] = 1'b1;
      rs_v[d]  = st;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_msg(input acc_t e, input string tag);
    int   a, d, bad, first_t;
    logic first_got, first_want;
    a = int'(e.c);
    d = int'(e.d);
    wait_until(a + BYTE_CYC * exp_n + 2);
    bad = 0;
    first_t = -1;
    first_got = 1'b0;
    first_want = 1'b0;
    for (int t = 1; t <= BYTE_CYC * exp_n; t++) begin
      int   k;
      int   j;
      int   s;
      logic want;
      k = t - 1;
      j = k / BYTE_CYC;
      s = (k % BYTE_CYC) / D;
      if (s == 0)      want = 1'b0;
      else if (s == 9) want = 1'b1;
      else             want = exp_b[j][s-1];
      if (tx_log[d][a+t] !== want) begin
        if (bad == 0) begin
          first_t = t;
          first_got = tx_log[d][a+t];
          first_want = want;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s wave dut%0d: %0d wrong cycles, first at offset %0d got %b want %b",
               tag, d, bad, first_t, first_got, first_want);
    end
    checks++;
    if (tx_log[d][a] !== 1'b1 || tx_log[d][a+1] !== 1'b0) begin
      errors++;
      $display("FAIL %s start_latency dut%0d: got %b%b, want 10", tag, d,
               tx_log[d][a], tx_log[d][a+1]);
    end
    for (int j = 0; j < exp_n; j++) begin
      int         base;
      logic [7:0] got;
      logic       st, sp;
      base = a + 1 + BYTE_CYC * j;
      st = tx_log[d][base + D/2];
      for (int b = 0; b < 8; b++) got[b] = tx_log[d][base + D*(b+1) + D/2];
      sp = tx_log[d][base + 9*D + D/2];
      checks++;
      if ({sp, got, st} !== {1'b1, exp_b[j], 1'b0}) begin
        errors++;
        $display("FAIL %s byte%0d dut%0d: got %02h (start %b stop %b), want %02h",
                 tag, j, d, got, st, sp, exp_b[j]);
      end
    end
    checks++;
    if (rdy_log[d][a] !== 1'b0 || rdy_log[d][a + BYTE_CYC*exp_n - 2] !== 1'b0 ||
        rdy_log[d][a + BYTE_CYC*exp_n - 1] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_span dut%0d: got %b%b%b, want 001 (accept period %0d)", tag, d,
               rdy_log[d][a], rdy_log[d][a + BYTE_CYC*exp_n - 2],
               rdy_log[d][a + BYTE_CYC*exp_n - 1], BYTE_CYC*exp_n);
    end
  endtask

  task automatic send(input int d, input logic on, input logic [3:0] ch, input logic [6:0] n,
                      input logic [6:0] v, input bit hold, output acc_t e, output bit ok);
    @(negedge clk);
    note_on  = on;
    channel  = ch;
    note_num = n;
    velocity = v;
    valid[d] = 1'b1;
    ok = 1'b0;
    e = '0;
    for (int i = 0; i < 4 * BYTE_CYC && !ok; i++) begin
      @(negedge clk);
      if (acc_q.size() > 0) begin
        e = acc_q.pop_front();
        ok = 1'b1;
      end
    end
    if (!hold || !ok) valid[d] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got no accept, want one within %0d cycles",
               d, 4 * BYTE_CYC);
    end
  endtask

  task automatic run_one(input int d, input logic on, input logic [3:0] ch, input logic [6:0] n,
                         input logic [6:0] v, input string tag);
    acc_t e;
    bit   ok;
    send(d, on, ch, n, v, 1'b0, e, ok);
    if (ok) begin
      model_msg(e);
      check_msg(e, tag);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    valid = '0;
    note_on = 1'b0;
    channel = '0;
    note_num = '0;
    velocity = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({tx[d], ready[d], busy[d]} !== 3'b110) begin
        errors++;
        $display("FAIL reset_state dut%0d: got tx/ready/busy %b%b%b, want 110",
                 d, tx[d], ready[d], busy[d]);
      end
      rs_ok[d] = 1'b0;
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_one(0, 1'b1, 4'd0, 7'd60, 7'd100, "basic_rs");
    run_one(1, 1'b1, 4'd0, 7'd60, 7'd100, "basic_nors");
  endtask

  task automatic test_running_status;
    run_one(0, 1'b1, 4'd0, 7'd64, 7'd90, "rs_skip");
    run_one(1, 1'b1, 4'd0, 7'd64, 7'd90, "rs_off");
  endtask

  task automatic test_note_off;
    run_one(0, 1'b0, 4'd3, 7'd60, 7'd64, "note_off");
    run_one(2, 1'b1, 4'd3, 7'd60, 7'd100, "vel0_on");
    run_one(2, 1'b0, 4'd3, 7'd60, 7'd64, "vel0_off");
  endtask

  task automatic test_back_to_back;
    acc_t e1, e2;
    bit   ok, got2;
    int   n1;
    send(0, 1'b1, 4'd9, 7'd33, 7'd77, 1'b1, e1, ok);
    if (!ok) return;
    got2 = 1'b0;
    e2 = '0;
    for (int i = 0; i < 4 * BYTE_CYC && !got2; i++) begin
      note_on  = 1'($urandom);
      channel  = 4'($urandom);
      note_num = 7'($urandom);
      velocity = 7'($urandom);
      @(negedge clk);
      if (acc_q.size() > 0) begin
        e2 = acc_q.pop_front();
        got2 = 1'b1;
      end
    end
    valid[0] = 1'b0;
    model_msg(e1);
    n1 = exp_n;
    check_msg(e1, "b2b_first");
    checks++;
    if (!got2 || int'(e2.c) != int'(e1.c) + BYTE_CYC * n1) begin
      errors++;
      $display("FAIL b2b_contiguous dut0: got second accept at %0d, want %0d",
               got2 ? int'(e2.c) : -1, int'(e1.c) + BYTE_CYC * n1);
      return;
    end
    model_msg(e2);
    check_msg(e2, "b2b_second");
  endtask

  task automatic test_max_data;
    run_one(1, 1'b1, 4'd5, 7'h7F, 7'h7F, "max_data");
  endtask

  task automatic test_reset_mid;
    acc_t e;
    bit   ok;
    send(0, 1'b1, 4'd0, 7'd60, 7'd100, 1'b0, e, ok);
    if (!ok) return;
    model_msg(e);
    wait_until(int'(e.c) + 1 + BYTE_CYC + 3 * D);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_tx dut0: got %b, want 1", tx[0]);
    end
    checks++;
    if (ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready dut0: got ready %b busy %b, want 1 0", ready[0], busy[0]);
    end
    reset_n = 1'b1;
    for (int d = 0; d < 3; d++) rs_ok[d] = 1'b0;
    run_one(0, 1'b1, 4'd0, 7'd60, 7'd100, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      run_one($urandom_range(0, 2), 1'($urandom), 4'($urandom_range(0, 3)),
              7'($urandom), 7'($urandom), "random");
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, want completion before 3 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_running_status();
    test_note_off();
    test_back_to_back();
    test_max_data();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
